// File: rtl/brightness_ctrl_pkg.sv
// Shared widths, defaults and repeat-FSM encoding for the front-panel brightness selector.
package brightness_ctrl_pkg;

    localparam int LEVEL_W       = 3;
    localparam int MAX_LEVEL_DEF = 4;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2
    } rep_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brightness_ctrl_btn_debounce_repeat.sv
// One front-panel button: 2-flop synchroniser, stability debounce, and hold-to-repeat step generator.
//
//   state      | meaning
//   REP_IDLE   | button released (or press not yet acted on)
//   REP_DELAY  | first step issued, waiting for the initial repeat delay
//   REP_REPEAT | auto-repeating at the repeat rate
module btn_debounce_repeat
    import brightness_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 32000,
    parameter int unsigned REP_DELAY_CYC = 1600000,
    parameter int unsigned REP_RATE_CYC  = 640000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    input  logic hold,
    output logic pressed,
    output logic step
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYC);
    localparam int unsigned TM_W = cnt_width((REP_DELAY_CYC > REP_RATE_CYC) ? REP_DELAY_CYC : REP_RATE_CYC);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TM_W-1:0] DELAY_LOAD = TM_W'(REP_DELAY_CYC - 1);
    localparam logic [TM_W-1:0] RATE_LOAD  = TM_W'(REP_RATE_CYC - 1);

    logic            sync_1, sync_2;
    logic            sample;
    logic [DB_W-1:0] db_cnt;
    rep_state_t      state, state_nxt;
    logic [TM_W-1:0] timer, timer_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
        end
    end

    assign sample = ~sync_2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pressed <= 1'b0;
            db_cnt  <= '0;
        end else if (sample == pressed) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            pressed <= sample;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= REP_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Timers are loaded with N-1 on entry so the step lands exactly N cycles later.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        step      = 1'b0;
        if (!pressed) begin
            state_nxt = REP_IDLE;
            timer_nxt = '0;
        end else if (!hold) begin
            case (state)
                REP_IDLE: begin
                    step      = 1'b1;
                    state_nxt = REP_DELAY;
                    timer_nxt = DELAY_LOAD;
                end
                REP_DELAY: begin
                    if (timer == '0) begin
                        step      = 1'b1;
                        state_nxt = REP_REPEAT;
                        timer_nxt = RATE_LOAD;
                    end else begin
                        timer_nxt = timer - TM_W'(1);
                    end
                end
                REP_REPEAT: begin
                    if (timer == '0) begin
                        step      = 1'b1;
                        timer_nxt = RATE_LOAD;
                    end else begin
                        timer_nxt = timer - TM_W'(1);
                    end
                end
                default: begin
                    state_nxt = REP_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/brightness_ctrl.sv
// Front-panel brightness selector: two debounced repeat buttons step a saturating level to the PWM stage.
// Define NIGHT_DIM_EN to cap the output at NIGHT_LEVEL during the GPS-timed night window.
module brightness_ctrl
    import brightness_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 32000,
    parameter int unsigned REP_DELAY_CYC = 1600000,
    parameter int unsigned REP_RATE_CYC  = 640000,
    parameter int unsigned MAX_LEVEL     = MAX_LEVEL_DEF,
`ifdef NIGHT_DIM_EN
    parameter int unsigned NIGHT_START   = 22,
    parameter int unsigned NIGHT_END     = 6,
    parameter int unsigned NIGHT_LEVEL   = 0,
`endif
    parameter int unsigned RESET_LEVEL   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up_n,
    input  logic               btn_dn_n,
    input  logic [4:0]         hour,
    input  logic               hour_valid,
    output logic [LEVEL_W-1:0] brightness,
    output logic               level_changed
);

    localparam logic [LEVEL_W-1:0] MAX_L   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] RESET_L = LEVEL_W'(RESET_LEVEL);

    logic               up_pressed, dn_pressed, both_pressed;
    logic               up_step, dn_step;
    logic [LEVEL_W-1:0] user_level, user_level_nxt, level_cap;

    assign both_pressed = up_pressed & dn_pressed;

    btn_debounce_repeat #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REP_DELAY_CYC(REP_DELAY_CYC),
        .REP_RATE_CYC (REP_RATE_CYC)
    ) u_btn_up (
        .clk    (clk),
        .reset  (reset),
        .btn_n  (btn_up_n),
        .hold   (both_pressed),
        .pressed(up_pressed),
        .step   (up_step)
    );

    btn_debounce_repeat #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REP_DELAY_CYC(REP_DELAY_CYC),
        .REP_RATE_CYC (REP_RATE_CYC)
    ) u_btn_dn (
        .clk    (clk),
        .reset  (reset),
        .btn_n  (btn_dn_n),
        .hold   (both_pressed),
        .pressed(dn_pressed),
        .step   (dn_step)
    );

    always_comb begin
        user_level_nxt = user_level;
        if (up_step && !dn_step && user_level < MAX_L)
            user_level_nxt = user_level + LEVEL_W'(1);
        else if (dn_step && !up_step && user_level != '0)
            user_level_nxt = user_level - LEVEL_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) user_level <= RESET_L;
        else        user_level <= user_level_nxt;
    end

`ifdef NIGHT_DIM_EN
    localparam logic [4:0]         N_START = 5'(NIGHT_START);
    localparam logic [4:0]         N_END   = 5'(NIGHT_END);
    localparam logic [LEVEL_W-1:0] N_LEVEL = LEVEL_W'(NIGHT_LEVEL);

    logic night;

    // Start after end means the window wraps through midnight; equal bounds give no night at all.
    always_comb begin
        night = 1'b0;
        if (hour_valid && hour <= 5'd23) begin
            if (N_START < N_END)
                night = (hour >= N_START) && (hour < N_END);
            else if (N_START > N_END)
                night = (hour >= N_START) || (hour < N_END);
        end
        level_cap = (night && user_level > N_LEVEL) ? N_LEVEL : user_level;
    end
`else
    logic unused_time;

    assign unused_time = ^{hour, hour_valid};
    assign level_cap   = user_level;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brightness    <= RESET_L;
            level_changed <= 1'b0;
        end else begin
            brightness    <= level_cap;
            level_changed <= (level_cap != brightness);
        end
    end

endmodule

// File: tb/tb_brightness_ctrl.sv
// Self-checking bench for brightness_ctrl: directed scenarios plus random button traffic against a behavioural model.
module tb_brightness_ctrl;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RR   = 8;
    localparam int MAXL = 4;
    localparam int RSTL = 2;
`ifdef NIGHT_DIM_EN
    localparam int NS = 22;
    localparam int NE = 6;
    localparam int NL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up_n = 1'b1;
    logic       btn_dn_n = 1'b1;
    logic [4:0] hour = 5'd0;
    logic       hour_valid = 1'b0;
    logic [2:0] brightness;
    logic       level_changed;

    brightness_ctrl #(
        .DEBOUNCE_CYC (D),
        .REP_DELAY_CYC(RD),
        .REP_RATE_CYC (RR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_up_n     (btn_up_n),
        .btn_dn_n     (btn_dn_n),
        .hour         (hour),
        .hour_valid   (hour_valid),
        .brightness   (brightness),
        .level_changed(level_changed)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pulse_at[$];
    int nxt_hour  = 0;
    int nxt_valid = 0;
    bit rel_req   = 0;

    // Behavioural model: per-button raw pipeline, debounced state, stable-run length, held time.
    int m_s1[2], m_s2[2], m_deb[2], m_run[2], m_k[2];
    int m_user, m_bright, m_chg;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int cap(input int lvl);
`ifdef NIGHT_DIM_EN
        bit night;
        int h;
        night = 0;
        h = int'(hour);
        if (hour_valid && h <= 23) begin
            if (NS < NE)      night = (h >= NS && h < NE);
            else if (NS > NE) night = (h >= NS || h < NE);
        end
        return (night && lvl > NL) ? NL : lvl;
`else
        return lvl;
`endif
    endfunction

    // Steps fall at held time 0, at the repeat delay, then every repeat interval.
    function automatic bit is_step_time(input int k);
        return (k == 0) || (k == RD) || (k > RD && ((k - RD) % RR) == 0);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 1; m_s2[b] = 1; m_deb[b] = 0; m_run[b] = 0; m_k[b] = 0;
        end
        m_user = RSTL; m_bright = RSTL; m_chg = 0;
    endtask

    task automatic model_edge(input int up_n, input int dn_n);
        int raw[2];
        int stp[2];
        int hold, sample, lvl;
        raw[0] = up_n; raw[1] = dn_n;
        hold = m_deb[0] && m_deb[1];
        for (int b = 0; b < 2; b++) stp[b] = m_deb[b] && !hold && is_step_time(m_k[b]);
        lvl      = cap(m_user);
        m_chg    = (lvl != m_bright);
        m_bright = lvl;
        if (stp[0] && !stp[1] && m_user < MAXL)   m_user = m_user + 1;
        else if (stp[1] && !stp[0] && m_user > 0) m_user = m_user - 1;
        for (int b = 0; b < 2; b++) begin
            if (!m_deb[b])  m_k[b] = 0;
            else if (!hold) m_k[b] = m_k[b] + 1;
            sample = !m_s2[b];
            if (sample == m_deb[b]) m_run[b] = 0;
            else begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == D) begin
                    m_deb[b] = sample;
                    m_run[b] = 0;
                end
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    task automatic run(input int up_n, input int dn_n, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check_eq("brightness", int'(brightness), m_bright);
            check_eq("level_changed", int'(level_changed), m_chg);
            if (level_changed) pulse_at.push_back(cyc);
            if (rel_req) begin
                reset   = 1'b1;
                rel_req = 0;
            end
            btn_up_n   = up_n[0];
            btn_dn_n   = dn_n[0];
            hour       = nxt_hour[4:0];
            hour_valid = nxt_valid[0];
            if (reset) model_edge(up_n, dn_n);
            else       model_reset();
            cyc++;
        end
    endtask

    // Asserts reset between edges, checks the immediate effect, and leaves release to the next run().
    task automatic async_reset(input int up_n, input int dn_n);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_eq("async_rst_brightness", int'(brightness), RSTL);
        check_eq("async_rst_changed", int'(level_changed), 0);
        model_reset();
        run(up_n, dn_n, 2);
        rel_req = 1;
    endtask

    initial begin
        model_reset();
        run(1, 1, 3);
        check_eq("reset_brightness", int'(brightness), RSTL);
        rel_req = 1;
        run(1, 1, 10);
        check_eq("idle_brightness", int'(brightness), RSTL);

        // Bouncing contact settles into a single press.
        pulse_at.delete();
        for (int i = 0; i < 5; i++) begin
            run(0, 1, 2);
            run(1, 1, 2);
        end
        run(0, 1, 12);
        run(1, 1, 12);
        check_eq("bounce_pulses", pulse_at.size(), 1);
        check_eq("bounce_level", int'(brightness), 3);

        // Hold UP from level 2: press step, delay step, then saturation.
        async_reset(1, 1);
        run(1, 1, 2);
        pulse_at.delete();
        run(0, 1, 60);
        check_eq("hold_up_pulses", pulse_at.size(), 2);
        if (pulse_at.size() == 2)
            check_eq("hold_up_delay", pulse_at[1] - pulse_at[0], RD);
        run(1, 1, 10);
        check_eq("hold_up_saturate", int'(brightness), MAXL);

        // Single DOWN presses to the bottom and one past it.
        for (int i = 0; i < 3; i++) begin
            run(1, 0, 10);
            run(1, 1, 10);
        end
        check_eq("down_to_1", int'(brightness), 1);
        run(1, 0, 10);
        run(1, 1, 10);
        check_eq("down_to_0", int'(brightness), 0);
        run(1, 0, 10);
        run(1, 1, 10);
        check_eq("down_floor", int'(brightness), 0);

        // Both buttons together: no steps and no repeats.
        run(0, 1, 10);
        run(1, 1, 10);
        pulse_at.delete();
        run(0, 0, 60);
        run(1, 1, 10);
        check_eq("both_pulses", pulse_at.size(), 0);
        check_eq("both_level", int'(brightness), 1);

        // UP held through reset release.
        run(0, 1, 15);
        async_reset(0, 1);
        pulse_at.delete();
        run(0, 1, 40);
        check_eq("held_rst_pulses", pulse_at.size(), 2);
        if (pulse_at.size() == 2)
            check_eq("held_rst_delay", pulse_at[1] - pulse_at[0], RD);
        run(1, 1, 10);

        // Random button traffic, with occasional mid-stream resets.
        for (int seg = 0; seg < 80; seg++) begin
            int u, d, len;
            u   = int'($urandom_range(0, 1));
            d   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            if ($urandom_range(0, 15) == 0) async_reset(u, d);
            run(u, d, len);
        end
        run(1, 1, 15);

`ifdef NIGHT_DIM_EN
        async_reset(1, 1);
        nxt_hour = 21; nxt_valid = 1;
        run(1, 1, 4);
        for (int i = 0; i < 2; i++) begin
            run(0, 1, 10);
            run(1, 1, 10);
        end
        check_eq("night_day_level", int'(brightness), 4);
        pulse_at.delete();
        nxt_hour = 22;
        run(1, 1, 4);
        check_eq("night_22_level", int'(brightness), 0);
        check_eq("night_22_pulses", pulse_at.size(), 1);
        nxt_hour = 5;
        run(1, 1, 4);
        check_eq("night_5_level", int'(brightness), 0);
        nxt_hour = 6;
        run(1, 1, 4);
        check_eq("night_6_level", int'(brightness), 4);
        nxt_hour = 23;
        run(1, 1, 4);
        check_eq("night_23_level", int'(brightness), 0);
        nxt_valid = 0;
        run(1, 1, 4);
        check_eq("night_invalid_level", int'(brightness), 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
